// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART token receiver.
//   - default bit period (100 MHz system clock, 115200 baud)
//   - ASCII codes used by the token parser
//   - receiver state encoding
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  function automatic logic is_sep(input logic [7:0] b);
    return (b == ASCII_SP) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial deframer.
// Ports:
//   clk        system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   uart_rx    raw serial line, idle high, LSB first
//   byte_data  last good byte (held between pulses)
//   byte_valid one-cycle pulse, byte_data is new
//   frame_err  one-cycle pulse, stop bit sampled low
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for falling edge on armed line
// START     | half-bit wait, confirm start bit still low
// DATA      | sampling 8 data bits, one per bit period
// STOP      | sampling stop bit
// WAIT_IDLE | after framing error, wait for line high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_s;
  logic [1:0]       sync_fill;
  logic             armed;
  rx_state_t        state;
  rx_state_t        nxt;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  logic tc;
  logic load_half;
  logic load_full;
  logic shift_en;
  logic byte_done;
  logic ferr;

  assign tc = (timer == '0);

  // The synchronizer resets to 1, which would look like an idle line even if
  // the pin is low. Only arm start detection once a real high has passed
  // through both flops, so a reset mid-frame never restarts on stale low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    ferr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !rx_s) begin
          nxt       = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (tc) begin
          if (!rx_s) begin
            nxt       = ST_DATA;
            load_full = 1'b1;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == 3'd7) nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tc) begin
          if (rx_s) begin
            byte_done = 1'b1;
            nxt       = ST_IDLE;
          end else begin
            ferr = 1'b1;
            nxt  = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (load_half)      timer <= HALF_LOAD;
      else if (load_full) timer <= FULL_LOAD;
      else if (!tc)       timer <= timer - 1'b1;

      if (load_half)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en)  shift     <= {rx_s, shift[7:1]};
      if (byte_done) byte_data <= shift;
      byte_valid <= byte_done;
      frame_err  <= ferr;
    end
  end

endmodule

// File: rtl/uart_token_rx.sv
// uart_token_rx: UART receiver plus decimal token parser.
// Digits accumulate into a number; a space/CR/LF ends the token and emits it.
// Ports:
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   uart_rx      serial line, 8N1, idle high
//   o_byte       last received byte
//   o_byte_valid one-cycle pulse, o_byte is new
//   o_num        last completed token value (saturated)
//   o_num_valid  one-cycle pulse, o_num is new
//   o_num_ovf    token exceeded 2^NUM_W-1 (only during o_num_valid)
//   o_tok_err    one-cycle pulse, illegal character
//   o_frame_err  one-cycle pulse, stop bit low
module uart_token_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  output logic [NUM_W-1:0] o_num,
  output logic             o_num_valid,
  output logic             o_num_ovf,
  output logic             o_tok_err,
  output logic             o_frame_err
);

  // Four spare bits cover acc*10+9 when acc is held at the saturation value.
  localparam int ACC_W = NUM_W + 4;
  localparam logic [ACC_W-1:0] NUM_MAX = {4'b0000, {NUM_W{1'b1}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             active;
  logic             ovf;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_data (o_byte),
    .byte_valid(o_byte_valid),
    .frame_err (o_frame_err)
  );

  // For '0'..'9' the low nibble is the digit value.
  assign acc_nxt = acc * ACC_W'(10) + ACC_W'(o_byte[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      active      <= 1'b0;
      ovf         <= 1'b0;
      o_num       <= '0;
      o_num_valid <= 1'b0;
      o_num_ovf   <= 1'b0;
      o_tok_err   <= 1'b0;
    end else begin
      o_num_valid <= 1'b0;
      o_num_ovf   <= 1'b0;
      o_tok_err   <= 1'b0;
      if (o_byte_valid) begin
        if (is_digit(o_byte)) begin
          active <= 1'b1;
          if (acc_nxt > NUM_MAX) begin
            acc <= NUM_MAX;
            ovf <= 1'b1;
          end else begin
            acc <= acc_nxt;
          end
        end else if (is_sep(o_byte)) begin
          if (active) begin
            o_num       <= acc[NUM_W-1:0];
            o_num_valid <= 1'b1;
            o_num_ovf   <= ovf;
            acc         <= '0;
            active      <= 1'b0;
            ovf         <= 1'b0;
          end
        end else begin
          o_tok_err <= 1'b1;
          acc       <= '0;
          active    <= 1'b0;
          ovf       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_token_rx.sv
module tb_uart_token_rx;
  import uart_pkg::*;

  localparam int CPB   = 48;
  localparam int NUM_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             uart_rx = 1'b1;
  logic [7:0]       o_byte;
  logic             o_byte_valid;
  logic [NUM_W-1:0] o_num;
  logic             o_num_valid;
  logic             o_num_ovf;
  logic             o_tok_err;
  logic             o_frame_err;

  int n_tot = 0;
  int n_bad = 0;

  // 100 ns clock: half a bit (24 cycles = 2400 ns) outlasts a 2000 ns glitch.
  always #50 clk = ~clk;

  uart_token_rx #(.CLKS_PER_BIT(CPB), .NUM_W(NUM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .o_byte      (o_byte),
    .o_byte_valid(o_byte_valid),
    .o_num       (o_num),
    .o_num_valid (o_num_valid),
    .o_num_ovf   (o_num_ovf),
    .o_tok_err   (o_tok_err),
    .o_frame_err (o_frame_err)
  );

  // Pulse monitor, sampled on the falling edge.
  logic [7:0] bq[$];
  int byte_cnt, num_cnt, tok_cnt, ferr_cnt;
  int last_num, last_ovf;
  int cyc = 0, bv_cyc = 0, num_lat = -1, tok_lat = -1;

  always @(negedge clk) begin
    cyc++;
    if (o_byte_valid) begin
      bq.push_back(o_byte);
      byte_cnt++;
      bv_cyc = cyc;
    end
    if (o_num_valid) begin
      num_cnt++;
      last_num = int'(o_num);
      last_ovf = int'(o_num_ovf);
      num_lat  = cyc - bv_cyc;
    end
    if (o_tok_err) begin
      tok_cnt++;
      tok_lat = cyc - bv_cyc;
    end
    if (o_frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic clr_mon();
    @(negedge clk);
    bq.delete();
    byte_cnt = 0; num_cnt = 0; tok_cnt = 0; ferr_cnt = 0;
    last_num = -1; last_ovf = -1; num_lat = -1; tok_lat = -1;
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
    bit_time(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte",  int'(o_byte), 0);
    chk("rst_num",   int'(o_num), 0);
    chk("rst_pulses", int'({o_byte_valid, o_num_valid, o_num_ovf, o_tok_err, o_frame_err}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // "2 " -> bytes 0x32, 0x20; one token 2
    clr_mon();
    send_str("2 ");
    chk("t1_bytes", byte_cnt, 2);
    chk("t1_b0", (bq.size() > 0) ? int'(bq[0]) : -1, 'h32);
    chk("t1_b1", (bq.size() > 1) ? int'(bq[1]) : -1, 'h20);
    chk("t1_nums", num_cnt, 1);
    chk("t1_num", last_num, 2);
    chk("t1_ovf", last_ovf, 0);
    chk("t1_lat", num_lat, 1);

    // "123\r\n" -> one token 123, LF ignored
    clr_mon();
    send_str("123\r\n");
    chk("t2_bytes", byte_cnt, 5);
    chk("t2_nums", num_cnt, 1);
    chk("t2_num", last_num, 123);

    // 70000 saturates, then 5 is clean
    clr_mon();
    send_str("70000 ");
    chk("t3_nums", num_cnt, 1);
    chk("t3_num", last_num, 65535);
    chk("t3_ovf", last_ovf, 1);
    clr_mon();
    send_str("5 ");
    chk("t3b_num", last_num, 5);
    chk("t3b_ovf", last_ovf, 0);
    repeat (20) @(negedge clk);
    chk("t3b_hold", int'(o_num), 5);
    chk("t3b_ovf_idle", int'(o_num_ovf), 0);

    // 0x33 with bad stop bit, then "4 "
    clr_mon();
    send_byte(8'h33, 1'b0);
    send_str("4 ");
    chk("t4_ferr", ferr_cnt, 1);
    chk("t4_bytes", byte_cnt, 2);
    chk("t4_b0", (bq.size() > 0) ? int'(bq[0]) : -1, 'h34);
    chk("t4_nums", num_cnt, 1);
    chk("t4_num", last_num, 4);

    // 2000 ns glitch, then "x "
    clr_mon();
    uart_rx = 1'b0;
    #2000;
    uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_bytes", byte_cnt, 0);
    chk("t5_ferr", ferr_cnt, 0);
    chk("t5_state", int'(dut.u_core.state), int'(ST_IDLE));
    send_str("x ");
    chk("t5_tok", tok_cnt, 1);
    chk("t5_toklat", tok_lat, 1);
    chk("t5_nums", num_cnt, 0);
    chk("t5_num_hold", int'(o_num), 4);

    // reset during bit 4 of '9' (0x39), held until the frame has ended
    clr_mon();
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'(8'h39 >> i));
    uart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_byte", int'(o_byte), 0);
    chk("t6_rst_num", int'(o_num), 0);
    chk("t6_rst_pulses", int'({o_byte_valid, o_num_valid, o_num_ovf, o_tok_err, o_frame_err}), 0);
    repeat (CPB / 2 - 2) @(negedge clk);
    for (int i = 5; i < 8; i++) bit_time(1'(8'h39 >> i));
    bit_time(1'b1);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    clr_mon();
    send_str("8 ");
    chk("t6_bytes", byte_cnt, 2);
    chk("t6_b0", (bq.size() > 0) ? int'(bq[0]) : -1, 'h38);
    chk("t6_nums", num_cnt, 1);
    chk("t6_num", last_num, 8);
    chk("t6_tok", tok_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_token_rx.md
UART_TOKEN_RX -- requirements
Module: uart_token_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter NUM_W, default 16, width of the decoded number.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port uart_rx  input  1  serial line from PC, 8N1, idle high, LSB first.
REQ-006 SHALL have port o_byte  output  8  last received byte.
REQ-007 SHALL have port o_byte_valid  output  1  one-cycle pulse: o_byte is new.
REQ-008 SHALL have port o_num  output  NUM_W  last completed decimal token value.
REQ-009 SHALL have port o_num_valid  output  1  one-cycle pulse: o_num is new.
REQ-010 SHALL have port o_num_ovf  output  1  qualifies o_num_valid: token exceeded 2^NUM_W-1.
REQ-011 SHALL have port o_tok_err  output  1  one-cycle pulse: illegal character inside the byte stream.
REQ-012 SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 SHALL implement receiver FSM IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: synchronized line low -> START, clear bit-timer.
REQ-016 START: at timer = CLKS_PER_BIT/2-1 sample; low -> DATA, high -> IDLE (glitch, no output).
REQ-017 DATA: sample 8 bits, each CLKS_PER_BIT clocks after previous sample, LSB first into shift register.
REQ-018 STOP: sample CLKS_PER_BIT clocks after bit 7; high -> o_byte/o_byte_valid on next edge, -> IDLE; low -> o_frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until synchronized line high, then IDLE.
REQ-020 Parser SHALL act only on o_byte_valid; digits '0'..'9' (0x30-0x39): acc = acc*10 + digit, set token-active.
REQ-021 Separators 0x20, 0x0D, 0x0A: if token-active, o_num = acc (saturated), o_num_valid pulse one cycle after o_byte_valid, clear acc/active/ovf; if not active, ignore (consecutive separators produce nothing).
REQ-022 Accumulation SHALL use at least NUM_W+4 bits internally; result > 2^NUM_W-1 sets sticky ovf, acc held at 2^NUM_W-1.
REQ-023 o_num_ovf SHALL equal sticky ovf during o_num_valid, 0 otherwise.
REQ-024 Any other byte: o_tok_err pulse one cycle after o_byte_valid, clear acc/active/ovf, no o_num_valid.
REQ-025 Frame error SHALL NOT affect parser state.
REQ-026 o_byte and o_num SHALL hold value between valid pulses.

Reset
REQ-027 On rst_n low: FSM IDLE, synchronizer 1, timers/shift/acc 0, o_byte 0, o_num 0, all pulses/flags 0.
REQ-028 Reset mid-frame SHALL abandon the byte; after release a byte is only accepted from a new falling edge (line must be seen high in IDLE first: IDLE entered via WAIT_IDLE semantics if line low at release).

Structure
REQ-029 Shared package uart_pkg SHALL hold CLKS_PER_BIT default, ASCII constants (0x30, 0x39, 0x20, 0x0D, 0x0A) and receiver state encoding.
REQ-030 Serial deframing SHALL be sub-module uart_rx_core (REQ-013..019); parser in top level.

Verification
REQ-031 Send "2"," " -> o_byte_valid twice (0x32, 0x20); one o_num_valid with o_num=2, o_num_ovf=0.
REQ-032 Send "1","2","3","\r","\n" -> single o_num_valid, o_num=123; no pulse for "\n".
REQ-033 Send "7","0","0","0","0"," " -> o_num=65535, o_num_ovf=1; following "5"," " -> o_num=5, ovf=0.
REQ-034 Send 0x33 with stop bit forced 0, then "4"," " -> o_frame_err pulse, no byte for 0x33, o_num=4.
REQ-035 Drive uart_rx low 2000 ns then high -> no o_byte_valid, FSM back in IDLE; "x"," " -> o_tok_err once, no o_num_valid.
REQ-036 Assert rst_n low during bit 4 of "9" -> all outputs 0; after release send "8"," " -> o_num=8 only.
